// File: rtl/adder_pkg.sv
// Shared definitions for the chunked sequential adder: state encoding,
// default geometry and a width sanity check.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } adder_state_t;

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit slice adder with carry in and carry out; the single
// shared adder stage of adder_chunked_seq.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_chunked_seq.sv
// Multi-cycle WIDTH-bit adder that processes one CHUNK-bit slice per clock.
// Optional macro SUB_EN enables subtract mode through the sub input.
module adder_chunked_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_geometry
            $error("adder_chunked_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    adder_state_t     state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

`ifdef SUB_EN
    // Subtraction is a + ~b + 1; the caller's carry-in is discarded.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c0         = cin;
`endif

    adder_chunk #(.W(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New slices enter at the top so the LSB slice ends up at the bottom.
    always_comb begin
        res_next = res >> CHUNK;
        res_next[WIDTH-1 -: CHUNK] = slice_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_eff;
                        carry <= c0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    res   <= res_next;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    // The final slice's top bit is the result MSB.
                    if (cnt == LAST) begin
                        sum      <= res_next;
                        cout     <= slice_cout;
                        overflow <= (a_msb == b_msb) && (slice_sum[CHUNK-1] != a_msb);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_chunked_seq.sv
// Scoreboard bench for adder_chunked_seq with directed vectors; expected
// results for the subtract vector depend on whether SUB_EN is defined.
module tb_adder_chunked_seq;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               issue;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   doneCount = 0;
    int   prevDoneCyc = 0;
    int   lastDoneCyc = 0;

    adder_chunked_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks result and latency.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            doneCount++;
            prevDoneCyc = lastDoneCyc;
            lastDoneCyc = cyc;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.sum));
                checkOutput("cout", 32'(cout), 32'(e.cout));
                checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                checkOutput("latency", 32'(cyc - e.issue), 32'(NCHUNK));
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv,
                                 input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{sum: es, cout: ec, ovf: eo, issue: cyc});
        start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] sub_sum;
        int d0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Carry ripples through every slice; busy for exactly NCHUNK cycles.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < NCHUNK; i++) begin
            @(negedge clk);
            checkOutput("busy_run", 32'(busy), 32'd1);
        end
        waitIdle();
        checkOutput("busy_after", 32'(busy), 32'd0);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        waitIdle();

        // A start pulse while busy must be ignored.
        d0 = doneCount;
        applyStimulus(16'h0003, 16'h000C, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (6) @(negedge clk);
        checkOutput("ignored_start_dones", 32'(doneCount - d0), 32'd1);

        // Back-to-back: start held high, second operands presented in the DONE cycle.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{sum: 16'h3333, cout: 1'b0, ovf: 1'b0, issue: cyc});
        for (int i = 0; i < 10 && done !== 1'b1; i++) @(negedge clk);
        a = 16'h8000; b = 16'h8000;
        @(posedge clk);
        #1;
        sb.push_back('{sum: 16'h0000, cout: 1'b1, ovf: 1'b1, issue: cyc});
        start = 1'b0;
        for (int i = 0; i < NCHUNK - 1; i++) begin
            @(negedge clk);
            checkOutput("b2b_sum_hold", 32'(sum), 32'h3333);
            checkOutput("b2b_busy", 32'(busy), 32'd1);
        end
        waitIdle();
        checkOutput("b2b_gap", 32'(lastDoneCyc - prevDoneCyc), 32'(NCHUNK + 1));

        // Reset during RUN aborts the operation and clears the results.
        d0 = doneCount;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        waitIdle();

`ifdef SUB_EN
        sub_sum = 16'hFFFE;
`else
        sub_sum = 16'h000C;
`endif
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, sub_sum, 1'b0, 1'b0);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_chunked_seq.md
Name: adder_chunked_seq

Overview:
Parametrised multi-cycle adder that sums two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, through a single CHUNK-bit adder stage. It is the successor to the fixed 4-bit combinational adder. It adds a start/busy/done handshake, registered results, signed-overflow detection and back-to-back operation. It is used wherever wide additions must share one small adder stage.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per cycle; must be ≥1 and ≤ WIDTH.
(derived) NCHUNK = WIDTH/CHUNK, cycles per operation.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when the block can accept.
a  input  WIDTH  operand A; captured on an accepted start.
b  input  WIDTH  operand B; captured on an accepted start.
cin  input  1  carry-in; captured on an accepted start.
sub  input  1  subtract mode; captured on an accepted start. Functional only with SUB_EN.
busy  output  1  high while slices are being computed.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  registered result.
cout  output  1  carry-out of bit WIDTH-1.
overflow  output  1  signed (two's-complement) overflow of the result.

Behaviour:
- Reset (synchronous, active-high) takes priority over everything else.
  - state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; internal slice counter, operand and carry registers cleared.
  - Reset mid-operation aborts the operation: no done pulse, outputs go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1 at edge E0:
  - capture a, b_eff, carry=c0; slice counter=0.
  - go to RUN; busy=1 from the cycle after E0.
- RUN: at each edge Ek (k=1..NCHUNK), add slice k-1 (LSB slice first):
  - {c, s} = a_slice + b_slice + carry;
  - store s into the internal result shift register; carry ← c.
  - start is ignored while busy=1; operands may change freely.
- At edge E_NCHUNK:
  - sum ← full internal result; cout ← final carry;
  - overflow ← (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]);
  - busy ← 0, done ← 1, state → DONE.
- Latency: done rises NCHUNK edges after the accepting edge. For the defaults that is 4 edges.
- DONE: lasts exactly one cycle.
  - If start=1 in this cycle, it is accepted: back-to-back, go directly to RUN, done drops next edge, busy=1.
  - Otherwise return to IDLE.
  - Throughput is one operation per NCHUNK+1 cycles when pipelined back-to-back.
- sum, cout and overflow change only at completion or reset. They hold their value through later IDLE and RUN cycles until the next completion; partial results are never visible.
- Arithmetic is modulo 2^WIDTH. cout is the true carry out; it is 1 for a=all-ones, b=0, cin=1.
- Without SUB_EN: b_eff=b, c0=cin.

Optional Feature:
Macro SUB_EN.
- Defined: when sub=1 is captured at accept, b_eff=~b and c0=1, so sum=a-b and cin is ignored. cout=1 means no borrow (a≥b unsigned). overflow follows the same rule using b_eff.
- Undefined: the sub port exists but is ignored (treated as 0). The b-inversion logic is not synthesised.

Decomposition:
- Shared package adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH/CHUNK localparams;
  - a width-check function (WIDTH % CHUNK == 0).
- One natural sub-module, adder_chunk: combinational CHUNK-bit adder with inputs a, b, cin and outputs sum, cout. It is instantiated once.
- Top level holds the FSM, slice counter, operand shift registers and result registers.

Test Plan:
1. Defaults; a=16'hFFFF, b=16'h0001, cin=0, start pulse → done exactly 4 edges later; sum=16'h0000, cout=1, overflow=0; busy high for 4 cycles.
2. a=16'h7FFF, b=16'h0001, cin=0 → sum=16'h8000, cout=0, overflow=1. Then a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0, overflow=0.
3. Start with a=16'h0003, b=16'h000C; while busy, pulse start with a=16'hFFFF → second start ignored; sum=16'h000F; exactly one done pulse.
4. Hold start=1 continuously with new operands presented in the DONE cycle → second operation accepted in the DONE cycle. Its done arrives 5 cycles after the first done; the first sum stays stable until the second completes.
5. Assert reset for 1 cycle at RUN slice 2 → next cycle busy=0, done=0, sum=0, cout=0, overflow=0; no done follows; a subsequent start behaves normally.
6. SUB_EN defined: a=16'h0005, b=16'h0007, sub=1, cin=0 → sum=16'hFFFE, cout=0, overflow=0. SUB_EN undefined, same stimulus → sum=16'h000C, cout=0.
